// File: rtl/counter_pkg.sv
// Shared constants for the interval counter and its host-side controller:
// state codes seen by the counter, command opcodes and the controller FSM encoding.
package counter_pkg;

   localparam logic [7:0] STATE_RESET = 8'd0;
   localparam logic [7:0] STATE_RUN   = 8'd1;
   localparam logic [7:0] STATE_HALT  = 8'd2;

   localparam logic [1:0] OP_CLEAR  = 2'b00;
   localparam logic [1:0] OP_START  = 2'b01;
   localparam logic [1:0] OP_HALT   = 2'b10;
   localparam logic [1:0] OP_RESUME = 2'b11;

   typedef enum logic [1:0] {
      FSM_CLR  = 2'd0,
      FSM_IDLE = 2'd1,
      FSM_RUN  = 2'd2,
      FSM_DONE = 2'd3
   } fsm_t;

endpackage

// File: rtl/counter_ctrl_if.sv
// Valid/ready command channel between the host (master) and counter_ctrl (slave).
interface counter_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_interval;
   logic [CNT_W-1:0] cmd_target;

   modport master (output cmd_valid, cmd_op, cmd_interval, cmd_target, input cmd_ready);
   modport slave  (input cmd_valid, cmd_op, cmd_interval, cmd_target, output cmd_ready);
endinterface

// File: rtl/counter.sv
// Interval counter: while in RUN it increments once every (interval + 1) clocks,
// clears on RESET and holds its value on HALT.
module counter
   import counter_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int STATE_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STATE_W-1:0] state,
   input  logic [CNT_W-1:0]   interval,
   output logic [CNT_W-1:0]   count
);

   logic [CNT_W-1:0] phase;

   // The phase keeps its value across HALT so a resumed count picks up mid-interval.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         phase <= '0;
      end else if (state == STATE_W'(STATE_RESET)) begin
         count <= '0;
         phase <= '0;
      end else if (state == STATE_W'(STATE_RUN)) begin
         if (phase == interval) begin
            count <= count + 1'b1;
            phase <= '0;
         end else begin
            phase <= phase + 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_ctrl.sv
// Host-side controller for one interval counter: command FSM plus target stop.
// Optional snapshot register is built only when COUNTER_CTRL_SNAPSHOT_EN is defined.
module counter_ctrl
   import counter_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int STATE_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   counter_ctrl_if.slave      cmd,
   output logic [STATE_W-1:0] state,
   output logic [CNT_W-1:0]   interval,
   input  logic [CNT_W-1:0]   counter,
   output logic               running,
   output logic               done,
   output logic               done_sticky,
   output logic [CNT_W-1:0]   snapshot
);

   fsm_t             state_q, state_d;
   logic             run_after_clr;
   logic [CNT_W-1:0] interval_r;
   logic [CNT_W-1:0] target_r;

   logic hit;
   logic is_reload_op;
   logic accept;
   logic accept_start;
   logic accept_reload;
   logic accept_halt;
   logic accept_resume;

   // A CLEAR/START arriving in the hit cycle is held off rather than accepted,
   // so the host keeps it pending and it lands on the following cycle in DONE.
   assign hit           = (state_q == FSM_RUN) && (target_r != '0) && (counter == target_r);
   assign is_reload_op  = (cmd.cmd_op == OP_CLEAR) || (cmd.cmd_op == OP_START);
   assign cmd.cmd_ready = (state_q != FSM_CLR) && !(hit && is_reload_op);
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;
   assign accept_start  = accept && (cmd.cmd_op == OP_START);
   assign accept_reload = accept && is_reload_op;
   assign accept_halt   = accept && (cmd.cmd_op == OP_HALT) && (state_q == FSM_RUN);
   assign accept_resume = accept && (cmd.cmd_op == OP_RESUME) && (state_q == FSM_IDLE);

   assign interval = interval_r;
   assign running  = (state_q == FSM_RUN);

   // The state code drops to HALT combinationally on a hit so the counter never overshoots.
   always_comb begin
      state_d = state_q;
      state   = STATE_W'(STATE_HALT);
      case (state_q)
         FSM_CLR: state = STATE_W'(STATE_RESET);
         FSM_RUN: if (!hit) state = STATE_W'(STATE_RUN);
         default: ;
      endcase
      if (state_q == FSM_CLR)
         state_d = run_after_clr ? FSM_RUN : FSM_IDLE;
      else if (hit)
         state_d = FSM_DONE;
      else if (accept_reload)
         state_d = FSM_CLR;
      else if (accept_halt)
         state_d = FSM_IDLE;
      else if (accept_resume)
         state_d = FSM_RUN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= FSM_CLR;
         run_after_clr <= 1'b0;
         interval_r    <= '0;
         target_r      <= '0;
         done          <= 1'b0;
         done_sticky   <= 1'b0;
      end else begin
         state_q       <= state_d;
         run_after_clr <= accept_start;
         done          <= hit;
         if (accept_start) begin
            interval_r <= cmd.cmd_interval;
            target_r   <= cmd.cmd_target;
         end
         if (hit)
            done_sticky <= 1'b1;
         else if (accept_reload)
            done_sticky <= 1'b0;
      end
   end

`ifdef COUNTER_CTRL_SNAPSHOT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         snapshot <= '0;
      else if (hit || accept_halt)
         snapshot <= counter;
      else if (accept_reload)
         snapshot <= '0;
   end
`else
   assign snapshot = '0;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl driving a counter instance; directed
// scenarios plus randomized commands, all compared against a cycle model.
module tb_counter_ctrl;
   import counter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  state;
   logic [31:0] interval, counter, snapshot;
   logic        running, done, done_sticky;

   counter_ctrl_if #(.CNT_W(32)) cmd_if ();

   counter_ctrl #(.CNT_W(32), .STATE_W(8)) dut (
      .clk(clk), .rst(rst), .cmd(cmd_if), .state(state), .interval(interval),
      .counter(counter), .running(running), .done(done), .done_sticky(done_sticky),
      .snapshot(snapshot)
   );

   counter #(.CNT_W(32), .STATE_W(8)) u_cnt (
      .clk(clk), .rst(rst), .state(state), .interval(interval), .count(counter)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: what the controller+counter pair should look like each cycle
   localparam int M_CLEARING = 0, M_STOPPED = 1, M_COUNTING = 2, M_FINISHED = 3;
   int          m_mode;
   logic        m_go;
   logic [31:0] m_count, m_phase, m_ival, m_tgt, m_snap;
   logic        m_sticky, m_done;

   logic [31:0] obs_count;
   logic [7:0]  obs_state;
   logic        obs_done, obs_sticky;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_hit();
      return (m_mode == M_COUNTING) && (m_tgt != 0) && (m_count == m_tgt);
   endfunction

   function automatic logic [7:0] model_code();
      if (m_mode == M_CLEARING) return 8'd0;
      if (m_mode == M_COUNTING && !model_hit()) return 8'd1;
      return 8'd2;
   endfunction

   function automatic logic model_ready(input logic [1:0] op);
      if (m_mode == M_CLEARING) return 1'b0;
      if (model_hit() && (op == OP_CLEAR || op == OP_START)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic modelReset();
      m_mode = M_CLEARING; m_go = 0; m_count = 0; m_phase = 0;
      m_ival = 0; m_tgt = 0; m_snap = 0; m_sticky = 0; m_done = 0;
   endtask

   task automatic modelStep(input logic v, input logic [1:0] op, input logic [31:0] iv, input logic [31:0] tg);
      logic [7:0]  code;
      logic        h, acc;
      int          n_mode;
      logic        n_go, n_sticky;
      logic [31:0] n_count, n_phase, n_ival, n_tgt, n_snap;
      code = model_code();
      h    = model_hit();
      acc  = v && model_ready(op);
      n_mode = m_mode; n_go = 0; n_sticky = m_sticky;
      n_ival = m_ival; n_tgt = m_tgt; n_snap = m_snap;
      n_count = m_count; n_phase = m_phase;
      if (code == 8'd0) begin
         n_count = 0; n_phase = 0;
      end else if (code == 8'd1) begin
         if (m_phase == m_ival) begin n_count = m_count + 1; n_phase = 0; end
         else n_phase = m_phase + 1;
      end
      if (m_mode == M_CLEARING) begin
         n_mode = m_go ? M_COUNTING : M_STOPPED;
      end else if (h) begin
         n_mode = M_FINISHED; n_sticky = 1; n_snap = m_count;
      end else if (acc) begin
         case (op)
            OP_CLEAR: begin n_mode = M_CLEARING; n_sticky = 0; n_snap = 0; end
            OP_START: begin
               n_mode = M_CLEARING; n_sticky = 0; n_snap = 0; n_go = 1;
               n_ival = iv; n_tgt = tg;
            end
            OP_HALT:   if (m_mode == M_COUNTING) begin n_mode = M_STOPPED; n_snap = m_count; end
            default:   if (m_mode == M_STOPPED) n_mode = M_COUNTING;
         endcase
      end
`ifndef COUNTER_CTRL_SNAPSHOT_EN
      n_snap = 0;
`endif
      m_done = h; m_mode = n_mode; m_go = n_go; m_sticky = n_sticky;
      m_ival = n_ival; m_tgt = n_tgt; m_snap = n_snap; m_count = n_count; m_phase = n_phase;
   endtask

   // One clock: drive at negedge, compare everything, advance the model at posedge
   task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] iv,
                                input logic [31:0] tg, output logic acc);
      @(negedge clk);
      cmd_if.cmd_valid = v; cmd_if.cmd_op = op;
      cmd_if.cmd_interval = iv; cmd_if.cmd_target = tg;
      #1;
      checkOutput("state", state, model_code());
      checkOutput("cmd_ready", cmd_if.cmd_ready, model_ready(op));
      checkOutput("running", running, m_mode == M_COUNTING);
      checkOutput("done", done, m_done);
      checkOutput("done_sticky", done_sticky, m_sticky);
      checkOutput("counter", counter, m_count);
      checkOutput("interval", interval, m_ival);
      checkOutput("snapshot", snapshot, m_snap);
      obs_count = counter; obs_state = state; obs_done = done; obs_sticky = done_sticky;
      acc = v && cmd_if.cmd_ready;
      @(posedge clk);
      modelStep(v, op, iv, tg);
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, OP_HALT, 32'd0, 32'd0, a);
   endtask

   task automatic sendCmd(input logic [1:0] op, input logic [31:0] iv, input logic [31:0] tg);
      logic a;
      a = 0;
      for (int i = 0; i < 8 && !a; i++) applyStimulus(1'b1, op, iv, tg, a);
      checkOutput("cmd_accept_timeout", a, 1);
   endtask

   task automatic waitCount(input logic [31:0] val, input int maxc, output logic ok);
      ok = 0;
      for (int i = 0; i < maxc && !ok; i++) begin
         idle(1);
         ok = (obs_count == val);
      end
   endtask

   task automatic waitModelHit(input int maxc, output logic ok);
      ok = model_hit();
      for (int i = 0; i < maxc && !ok; i++) begin
         idle(1);
         ok = model_hit();
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      cmd_if.cmd_valid = 0;
      rst = 1;
      #1;
      checkOutput("rst_state", state, 8'd0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_sticky", done_sticky, 0);
      checkOutput("rst_snapshot", snapshot, 0);
      checkOutput("rst_counter", counter, 0);
      modelReset();
      @(posedge clk);
      @(posedge clk);
      #2 rst = 0;
   endtask

   initial begin
      logic        ok, a, hold, saw5;
      logic [1:0]  h_op;
      logic [31:0] h_iv, h_tg;
      int          pulses, r;

      rst = 1;
      cmd_if.cmd_valid = 0; cmd_if.cmd_op = OP_CLEAR;
      cmd_if.cmd_interval = 0; cmd_if.cmd_target = 0;
      modelReset();
      repeat (2) @(posedge clk);
      #2 rst = 0;

      // Reset release: one cycle of RESET code, then HALT
      idle(1);
      checkOutput("boot_state0", obs_state, 8'd0);
      idle(3);
      checkOutput("boot_state2", obs_state, 8'd2);
      checkOutput("boot_counter", obs_count, 0);

      // Target stop at 5
      sendCmd(OP_START, 32'd3, 32'd5);
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         idle(1);
         pulses += int'(obs_done);
      end
      checkOutput("t5_pulses", pulses, 1);
      checkOutput("t5_final", obs_count, 5);
      checkOutput("t5_sticky", obs_sticky, 1);

      // Halt/resume, unbounded target
      sendCmd(OP_START, 32'd2, 32'd0);
      waitCount(32'd4, 40, ok);
      checkOutput("hr_reach4", ok, 1);
      sendCmd(OP_HALT, 32'd0, 32'd0);
      idle(10);
      checkOutput("hr_hold4", obs_count, 4);
`ifdef COUNTER_CTRL_SNAPSHOT_EN
      checkOutput("hr_snapshot", snapshot, 4);
`else
      checkOutput("hr_snapshot", snapshot, 0);
`endif
      sendCmd(OP_RESUME, 32'd0, 32'd0);
      saw5 = 0; ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         idle(1);
         if (obs_count == 5) saw5 = 1;
         ok = (obs_count == 6);
      end
      checkOutput("hr_saw5", saw5, 1);
      checkOutput("hr_reach6", ok, 1);

      // Interval 0, target 1: no overshoot
      sendCmd(OP_START, 32'd0, 32'd1);
      waitCount(32'd1, 10, ok);
      checkOutput("t1_reach", ok, 1);
      checkOutput("t1_state_at_hit", obs_state, 8'd2);
      idle(5);
      checkOutput("t1_final", obs_count, 1);

      // HALT in the hit cycle is accepted and dropped
      sendCmd(OP_START, 32'd0, 32'd3);
      waitModelHit(20, ok);
      checkOutput("col_hit", ok, 1);
      applyStimulus(1'b1, OP_HALT, 32'd0, 32'd0, a);
      checkOutput("col_halt_acc", a, 1);
      idle(1);
      checkOutput("col_done", obs_done, 1);
      checkOutput("col_sticky", obs_sticky, 1);
      sendCmd(OP_CLEAR, 32'd0, 32'd0);
      idle(3);
      checkOutput("col_clr_count", obs_count, 0);
      checkOutput("col_clr_sticky", obs_sticky, 0);

      // CLEAR in the hit cycle is held off, then applied
      sendCmd(OP_START, 32'd0, 32'd2);
      waitModelHit(20, ok);
      applyStimulus(1'b1, OP_CLEAR, 32'd0, 32'd0, a);
      checkOutput("col_clear_held", a, 0);
      sendCmd(OP_CLEAR, 32'd0, 32'd0);
      idle(3);
      checkOutput("col_clear_count", obs_count, 0);

      // Reset while running at count 7
      sendCmd(OP_START, 32'd0, 32'd0);
      for (int i = 0; i < 30 && m_count != 7; i++) idle(1);
      checkOutput("rr_at7", m_count, 7);
      doReset();
      idle(1);
      checkOutput("rr_state0", obs_state, 8'd0);
      idle(1);
      checkOutput("rr_state2", obs_state, 8'd2);
      checkOutput("rr_count", obs_count, 0);

      // Randomized command traffic; the host holds a command until it is taken
      hold = 0; h_op = OP_CLEAR; h_iv = 0; h_tg = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!hold && $urandom_range(0, 3) == 0) begin
            hold = 1;
            r = int'($urandom_range(0, 9));
            h_op = (r < 2) ? OP_START : (r < 3) ? OP_CLEAR : (r < 6) ? OP_HALT : OP_RESUME;
            h_iv = $urandom_range(0, 3);
            h_tg = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
         end
         if ($urandom_range(0, 499) == 0) begin
            doReset();
            hold = 0;
         end
         applyStimulus(hold, h_op, h_iv, h_tg, a);
         if (a) hold = 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
